// File: rtl/gf64_reduce_pipe_if.sv
// Valid/ready bus for the GF(2^64) reduction stage: 128-bit product in, 64-bit element out.
interface gf64_reduce_pipe_if;
    localparam int unsigned PROD_W = 128;
    localparam int unsigned RES_W  = 64;

    logic              in_valid;
    logic              in_ready;
    logic [PROD_W-1:0] in_prod;
    logic              out_valid;
    logic              out_ready;
    logic [RES_W-1:0]  out_res;

    modport master (
        output in_valid, in_prod, out_ready,
        input  in_ready, out_valid, out_res
    );

    modport slave (
        input  in_valid, in_prod, out_ready,
        output in_ready, out_valid, out_res
    );
endinterface

// File: rtl/gf64_reduce_pipe.sv
// Two-fold pipelined reduction of a 128-bit carry-less product modulo x^64 + R_POLY.
// Optional sticky upstream-corruption flag (in_prod[127] set) under GF64_RED_ERRCHK_EN.
module gf64_reduce_pipe #(
    parameter logic [63:0] R_POLY = 64'h1B
) (
    input  logic clk,
    input  logic rst,
    gf64_reduce_pipe_if.slave bus
`ifdef GF64_RED_ERRCHK_EN
    ,
    output logic err
`endif
);
    localparam int unsigned RES_W  = 64;
    localparam int unsigned F_W    = 96;
    localparam int unsigned FHI_W  = 32;

    // hi * R: R has degree <= 31, so the product fits in 96 bits
    function automatic logic [F_W-1:0] clmul_hi(input logic [RES_W-1:0] a);
        logic [F_W-1:0] acc;
        acc = '0;
        for (int i = 0; i < 32; i++) begin
            if (R_POLY[i]) acc = acc ^ (F_W'(a) << i);
        end
        return acc;
    endfunction

    // Second fold: 32-bit overflow times R stays below x^63
    function automatic logic [RES_W-1:0] clmul_lo(input logic [FHI_W-1:0] a);
        logic [RES_W-1:0] acc;
        acc = '0;
        for (int i = 0; i < 32; i++) begin
            if (R_POLY[i]) acc = acc ^ (RES_W'(a) << i);
        end
        return acc;
    endfunction

    logic             r_s1_v;
    logic [F_W-1:0]   r_s1_f;
    logic [RES_W-1:0] r_s1_lo;
    logic             r_s2_v;
    logic [RES_W-1:0] r_s2_res;

    logic             w_s2_load;
    logic             w_s1_adv;
    logic             w_in_ready;
    logic             w_in_xfer;
    logic [F_W-1:0]   w_f;
    logic [RES_W-1:0] w_fold;

    assign w_s2_load  = ~r_s2_v | bus.out_ready;
    assign w_s1_adv   = r_s1_v & w_s2_load;
    assign w_in_ready = ~rst & (~r_s1_v | w_s2_load);
    assign w_in_xfer  = bus.in_valid & w_in_ready;
    assign w_f        = clmul_hi(bus.in_prod[127:64]);
    assign w_fold     = r_s1_lo ^ r_s1_f[63:0] ^ clmul_lo(r_s1_f[95:64]);

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_s2_v;
    assign bus.out_res   = r_s2_res;

    // Stage 1: first fold of the high half
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_v  <= 1'b0;
            r_s1_f  <= '0;
            r_s1_lo <= '0;
        end else if (w_in_xfer) begin
            r_s1_v  <= 1'b1;
            r_s1_f  <= w_f;
            r_s1_lo <= bus.in_prod[63:0];
        end else if (w_s1_adv) begin
            r_s1_v  <= 1'b0;
        end
    end

    // Stage 2: second fold and final sum; data holds across bubbles
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s2_v   <= 1'b0;
            r_s2_res <= '0;
        end else if (w_s2_load) begin
            r_s2_v <= r_s1_v;
            if (r_s1_v) r_s2_res <= w_fold;
        end
    end

`ifdef GF64_RED_ERRCHK_EN
    logic r_err;

    // Bit 127 can never be set by a 64x64 product
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if (w_in_xfer && bus.in_prod[127]) begin
            r_err <= 1'b1;
        end
    end

    assign err = r_err;
`endif
endmodule

// File: tb/tb_gf64_reduce_pipe.sv
// Scoreboard bench for gf64_reduce_pipe; reference reduces bit by bit from x^127 down.
module tb_gf64_reduce_pipe;
    localparam logic [63:0] R_POLY = 64'h1B;

    logic clk;
    logic rst;
    gf64_reduce_pipe_if bus ();
`ifdef GF64_RED_ERRCHK_EN
    logic err;
`endif

    gf64_reduce_pipe #(.R_POLY(R_POLY)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
`ifdef GF64_RED_ERRCHK_EN
        ,
        .err (err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int rx_count = 0;
    logic [63:0] exp_q[$];
    bit          stall_prev = 1'b0;
    logic [63:0] res_prev   = '0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // x^i for i >= 64 is rewritten as x^(i-64) * R until nothing above x^63 remains
    function automatic logic [63:0] ref_mod(input logic [127:0] p);
        logic [127:0] v;
        v = p;
        for (int i = 127; i >= 64; i--) begin
            if (v[i]) v = v ^ (128'(R_POLY) << (i - 64)) ^ (128'(1) << i);
        end
        return v[63:0];
    endfunction

    // Output side: pop/compare on transfer, push on input transfer, stall stability
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                chk("stall_valid_hold", 64'(bus.out_valid), 64'd1);
                chk("stall_res_hold", bus.out_res, res_prev);
            end
            stall_prev = bus.out_valid && !bus.out_ready;
            res_prev   = bus.out_res;
            if (bus.out_valid && bus.out_ready) begin
                rx_count++;
                chk("sb_output_expected", 64'(exp_q.size() != 0), 64'd1);
                if (exp_q.size() != 0) chk("sb_result", bus.out_res, exp_q.pop_front());
            end
            if (bus.in_valid && bus.in_ready) exp_q.push_back(ref_mod(bus.in_prod));
        end
    end

    task automatic send(input logic [127:0] p);
        int n;
        n = 0;
        bus.in_valid = 1'b1;
        bus.in_prod  = p;
        #1;
        while (!bus.in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk("send_accept_timeout", 64'(n < 50), 64'd1);
        @(posedge clk); #1;
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk(tag, 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] items [8];
        bit           pat   [8];
        int           idx;
        int           cyc;
        int           rx_base;
        bit           xfer;

        pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_prod   = '0;
        bus.out_ready = 1'b0;

        // Reset state
        @(posedge clk); #1;
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_out_res", bus.out_res, 64'd0);
        chk("rst_in_ready", 64'(bus.in_ready), 64'd0);
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", 64'(bus.in_ready), 64'd1);
`ifdef GF64_RED_ERRCHK_EN
        chk("rst_err", 64'(err), 64'd0);
`endif
        @(posedge clk); #1;

        // hi = 0 passes lo through; latency of exactly two cycles
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_prod   = {64'h0, 64'h0123_4567_89AB_CDEF};
        #1;
        chk("lat_in_ready", 64'(bus.in_ready), 64'd1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        chk("lat_cycle1_valid", 64'(bus.out_valid), 64'd0);
        @(posedge clk); #1;
        chk("lat_cycle2_valid", 64'(bus.out_valid), 64'd1);
        chk("passthru_res", bus.out_res, 64'h0123_4567_89AB_CDEF);
        @(posedge clk); #1;
        chk("passthru_no_dup", 64'(bus.out_valid), 64'd0);
        drain("drain_passthru");

        // x^64 -> R, then x^64 + R -> 0, back to back
        send({64'h1, 64'h0});
        send({64'h1, 64'h1B});
        bus.in_valid = 1'b0;
        chk("x64_res", bus.out_res, 64'h1B);
        @(posedge clk); #1;
        chk("x64_plus_r_valid", 64'(bus.out_valid), 64'd1);
        chk("x64_plus_r_res", bus.out_res, 64'h0);
        drain("drain_x64");

        // x^127 exercises both folds
`ifdef GF64_RED_ERRCHK_EN
        chk("err_before_x127", 64'(err), 64'd0);
`endif
        send({64'h8000_0000_0000_0000, 64'h0});
        bus.in_valid = 1'b0;
`ifdef GF64_RED_ERRCHK_EN
        chk("err_after_x127", 64'(err), 64'd1);
`endif
        @(posedge clk); #1;
        chk("x127_valid", 64'(bus.out_valid), 64'd1);
        chk("x127_res", bus.out_res, 64'h8000_0000_0000_00AF);
        drain("drain_x127");

        // Back-to-back random stream with toggling out_ready
        for (int i = 0; i < 8; i++) begin
            items[i] = {$urandom(), $urandom(), $urandom(), $urandom()};
            items[i][127] = 1'b0;
        end
        rx_base = rx_count;
        idx = 0;
        cyc = 0;
        while (idx < 8 && cyc < 200) begin
            bus.in_valid  = 1'b1;
            bus.in_prod   = items[idx];
            bus.out_ready = pat[cyc % 8];
            #1;
            chk("stream_in_ready", 64'(bus.in_ready),
                64'(!(exp_q.size() == 2 && !bus.out_ready)));
            xfer = bus.in_ready;
            @(posedge clk); #1;
            if (xfer) idx++;
            cyc++;
        end
        chk("stream_all_accepted", 64'(idx), 64'd8);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        drain("drain_stream");
        chk("stream_rx_count", 64'(rx_count - rx_base), 64'd8);
`ifdef GF64_RED_ERRCHK_EN
        chk("err_sticky", 64'(err), 64'd1);
`endif

        // Fill the pipe under stall, then reset mid-cycle
        bus.out_ready = 1'b0;
        send({64'hDEAD_BEEF_0000_0001, 64'h1111_2222_3333_4444});
        send({64'h0000_0000_FFFF_FFFF, 64'h5555_6666_7777_8888});
        bus.in_valid = 1'b0;
        chk("full_out_valid", 64'(bus.out_valid), 64'd1);
        chk("full_in_ready", 64'(bus.in_ready), 64'd0);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("async_rst_out_res", bus.out_res, 64'd0);
        chk("async_rst_in_ready", 64'(bus.in_ready), 64'd0);
        @(posedge clk);
        @(posedge clk); #1;
        rst = 1'b0;
        bus.out_ready = 1'b1;
        #1;
        chk("release_in_ready", 64'(bus.in_ready), 64'd1);
`ifdef GF64_RED_ERRCHK_EN
        chk("release_err", 64'(err), 64'd0);
`endif
        rx_base = rx_count;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("no_stale_valid", 64'(bus.out_valid), 64'd0);
        end
        chk("no_stale_rx", 64'(rx_count - rx_base), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/gf64_reduce_pipe.md
Name: gf64_reduce_pipe

Overview:
- Downstream stage of the 64x64 carry-less (GF(2)[x]) Karatsuba multiplier.
- Takes the 128-bit unreduced product and reduces it modulo P(x) = x^64 + R(x), producing a 64-bit GF(2^64) element.
- Two-stage fold pipeline with valid/ready handshakes on both sides.
- Sustains one reduction per cycle.

Parameters:
- R_POLY, 64'h1B, low part of the modulus (P = x^64 + R_POLY; default x^64+x^4+x^3+x+1); bits [63:32] must be 0, otherwise two folds are insufficient.

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  reset, asynchronous, active-high
- in_valid  input  1  in_prod is valid
- in_ready  output  1  stage can accept in_prod this cycle
- in_prod  input  128  unreduced carry-less product; [127:64]=hi, [63:0]=lo
- out_valid  output  1  out_res is valid
- out_ready  input  1  consumer accepts out_res this cycle
- out_res  output  64  in_prod mod P(x)

Behaviour:
- One clock (clk); reset rst is asynchronous and active-high.
- Arithmetic is over GF(2) only: addition is XOR, clmul is carry-less multiply, no carries anywhere.
- Stage 1 on input transfer (in_valid & in_ready):
  - s1_f[95:0] <= clmul(hi, R_POLY)
  - s1_lo <= lo
  - s1_v <= 1
- Stage 2 when stage 1 advances:
  - s2_res <= s1_lo ^ s1_f[63:0] ^ clmul(s1_f[95:64], R_POLY)[63:0]
  - The upper bits of the second clmul are provably 0 because deg < 63.
- out_res = s2_res; out_valid = s2_v.
- Latency: exactly 2 cycles from input transfer to out_valid when not stalled. Throughput is 1 per cycle.
- Advance rules:
  - s2 loads when !s2_v | out_ready.
  - s1 advances when s1_v & (!s2_v | out_ready).
  - in_ready = !s1_v | !s2_v | out_ready. This is combinational from out_ready; there is no combinational path from in_valid.
- Stall: while out_valid & !out_ready, out_res and out_valid hold stable and no data is lost or duplicated.
- When the pipe is full, the stall propagates to in_ready in the same cycle.
- Bubbles: if s1 is empty and s2 advances, s2_v <= 0 when out_ready is high.
- Simultaneous in/out transfer on a full pipe: every stage shifts by one and ordering is preserved.
- Reset (async, any time including mid-stall):
  - s1_v = s2_v = 0; all data regs = 0.
  - out_valid = 0, out_res = 0.
  - in_ready = 0 while rst is high, 1 on the first cycle after release.
  - In-flight data is discarded.
- Ordering: results leave in strict acceptance order.
- Protocol: upstream must hold in_prod stable while in_valid & !in_ready. The block does not depend on this, because it samples only on transfer.

Optional Feature:
- Macro: GF64_RED_ERRCHK_EN.
- Defined:
  - Extra port `err  output  1`, a sticky flag.
  - err is set in the cycle after any input transfer with in_prod[127]=1. A 64x64 product can never set bit 127, so this bit indicates upstream corruption.
  - err is cleared only by rst (reset value 0).
  - The datapath result is still computed normally.
- Undefined:
  - No err port and no extra logic.
  - in_prod[127] is reduced like any other bit.

Test Plan:
- hi=0, lo=64'h0123_4567_89AB_CDEF, out_ready=1 -> out_res=64'h0123_4567_89AB_CDEF, out_valid exactly 2 cycles after transfer.
- hi=64'h1, lo=0 (x^64) -> out_res=64'h1B; then hi=64'h1, lo=64'h1B -> out_res=0.
- in_prod=128'h8000_0000_0000_0000_0000_0000_0000_0000 (x^127) -> out_res=64'h8000_0000_0000_00AF. With GF64_RED_ERRCHK_EN, err=1 next cycle and it stays 1 until rst.
- Back-to-back stream of 8 random products, out_ready toggled 1,0,0,1,0,1,1,0 -> every result matches the software model (bitwise clmul then mod P) in order, none dropped or duplicated. in_ready=0 whenever both stages are full and out_ready=0.
- Pipe full (two products accepted, out_ready=0), assert rst mid-cycle -> out_valid=0 and out_res=0 immediately. After release, in_ready=1 and no stale result ever appears.
